// File: rtl/calc_ctrl_unit_pkg.sv
// Shared types and constants for the register-file calculator control unit.
//   state_t : Moore state encoding (also exported on CS for debug)
//   OP_*    : ALU op-code values
//   SEL1_*  : write-data mux select codes
package calc_pkg;

  localparam int unsigned CS_W   = 3;
  localparam int unsigned SEL1_W = 2;

  typedef enum logic [CS_W-1:0] {
    ST_IDLE  = 3'b000,
    ST_LOADA = 3'b001,
    ST_LOADB = 3'b010,
    ST_EXEC  = 3'b011,
    ST_DISP  = 3'b100,
    ST_ERROR = 3'b101
  } state_t;

  localparam int unsigned OP_XOR = 0;
  localparam int unsigned OP_AND = 1;
  localparam int unsigned OP_SUB = 2;
  localparam int unsigned OP_ADD = 3;
  localparam int unsigned OP_OR  = 4;

  localparam logic [SEL1_W-1:0] SEL1_IN_A = 2'b11;
  localparam logic [SEL1_W-1:0] SEL1_IN_B = 2'b10;
  localparam logic [SEL1_W-1:0] SEL1_ALU  = 2'b00;
  localparam logic [SEL1_W-1:0] SEL1_IDLE = 2'b01;

endpackage

// File: rtl/calc_ctrl_unit_if.sv
// Handshake and datapath-control bundle between the calculator control unit
// and its environment.
//   Go/Chain/Op      : start request, chain mode and op code (to the unit)
//   Sel1/WA/WE       : register-file write port control
//   RAA/RAB/REA/REB  : register-file read port control
//   C/Sel2           : ALU op code and output-register load
//   Done/Busy/Err/CS : status and debug state
// master = requester side, slave = control unit side.
interface calc_ctrl_unit_if #(
  parameter int unsigned AW  = 2,
  parameter int unsigned OPW = 3
);
  import calc_pkg::*;

  logic              Go;
  logic              Chain;
  logic [OPW-1:0]    Op;
  logic [SEL1_W-1:0] Sel1;
  logic [AW-1:0]     WA;
  logic              WE;
  logic [AW-1:0]     RAA;
  logic [AW-1:0]     RAB;
  logic              REA;
  logic              REB;
  logic [OPW-1:0]    C;
  logic              Sel2;
  logic              Done;
  logic              Busy;
  logic              Err;
  logic [CS_W-1:0]   CS;

  modport master (
    output Go, Chain, Op,
    input  Sel1, WA, WE, RAA, RAB, REA, REB, C, Sel2, Done, Busy, Err, CS
  );

  modport slave (
    input  Go, Chain, Op,
    output Sel1, WA, WE, RAA, RAB, REA, REB, C, Sel2, Done, Busy, Err, CS
  );

endinterface

// File: rtl/calc_ctrl_unit_decode.sv
// Moore output decoder: maps (state, latched op, latched chain) to the
// datapath control word. Purely combinational; no input-to-output path
// exists because every input here is a register in the top level.
//   cs_i, op_i, chain_i : current state and latched request
//   *_o                 : control word fields
module calc_ctrl_decode
  import calc_pkg::*;
#(
  parameter int unsigned AW     = 2,
  parameter int unsigned OPW    = 3,
  parameter int unsigned A_ADDR = 1,
  parameter int unsigned B_ADDR = 2,
  parameter int unsigned R_ADDR = 3,
  parameter int unsigned C_PASS = 1
) (
  input  state_t            cs_i,
  input  logic [OPW-1:0]    op_i,
  input  logic              chain_i,
  output logic [SEL1_W-1:0] sel1_o,
  output logic [AW-1:0]     wa_o,
  output logic              we_o,
  output logic [AW-1:0]     raa_o,
  output logic [AW-1:0]     rab_o,
  output logic              rea_o,
  output logic              reb_o,
  output logic [OPW-1:0]    c_o,
  output logic              sel2_o,
  output logic              done_o,
  output logic              busy_o,
  output logic              err_o
);

  // Control word per state; anything not set stays at its idle value.
  always_comb begin
    sel1_o = SEL1_IDLE;
    wa_o   = '0;
    we_o   = 1'b0;
    raa_o  = '0;
    rab_o  = '0;
    rea_o  = 1'b0;
    reb_o  = 1'b0;
    c_o    = '0;
    sel2_o = 1'b0;
    done_o = 1'b0;
    busy_o = 1'b1;
    err_o  = 1'b0;
    case (cs_i)
      ST_IDLE: busy_o = 1'b0;
      ST_LOADA: begin
        sel1_o = SEL1_IN_A;
        wa_o   = AW'(A_ADDR);
        we_o   = 1'b1;
      end
      ST_LOADB: begin
        sel1_o = SEL1_IN_B;
        wa_o   = AW'(B_ADDR);
        we_o   = 1'b1;
      end
      ST_EXEC: begin
        sel1_o = SEL1_ALU;
        wa_o   = AW'(R_ADDR);
        we_o   = 1'b1;
        // Chain mode reads the previous result in place of operand A.
        raa_o  = chain_i ? AW'(R_ADDR) : AW'(A_ADDR);
        rab_o  = AW'(B_ADDR);
        rea_o  = 1'b1;
        reb_o  = 1'b1;
        c_o    = op_i;
      end
      ST_DISP: begin
        raa_o  = AW'(R_ADDR);
        rab_o  = AW'(R_ADDR);
        rea_o  = 1'b1;
        reb_o  = 1'b1;
        c_o    = OPW'(C_PASS);
        sel2_o = 1'b1;
        done_o = 1'b1;
      end
      ST_ERROR: err_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/calc_ctrl_unit.sv
// Control unit for the register-file calculator: sequences operand load,
// execute and display, with latched op code, illegal-op detection, chain
// mode and Busy/Done handshake.
//   CLK : clock, rising edge
//   RST : asynchronous active-high reset
//   bus : request inputs and datapath control outputs (slave side)
module calc_ctrl_unit
  import calc_pkg::*;
#(
  parameter int unsigned AW      = 2,
  parameter int unsigned OPW     = 3,
  parameter int unsigned NUM_OPS = 5,
  parameter int unsigned A_ADDR  = 1,
  parameter int unsigned B_ADDR  = 2,
  parameter int unsigned R_ADDR  = 3,
  parameter int unsigned C_PASS  = 1
) (
  input logic             CLK,
  input logic             RST,
  calc_ctrl_unit_if.slave bus
);

  state_t         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic           chain_q, chain_d;
  logic           res_valid_q, res_valid_d;
  logic           op_illegal;

  assign op_illegal = (32'(bus.Op) >= NUM_OPS);

  // State and request registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      chain_q     <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      chain_q     <= chain_d;
      res_valid_q <= res_valid_d;
    end
  end

  // Next-state logic; Op/Chain are only captured on an accepted Go in IDLE.
  always_comb begin
    state_d     = ST_IDLE;
    op_d        = op_q;
    chain_d     = chain_q;
    res_valid_d = res_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.Go) begin
          op_d    = bus.Op;
          chain_d = bus.Chain;
          if (op_illegal || (bus.Chain && !res_valid_q)) state_d = ST_ERROR;
          else if (bus.Chain)                            state_d = ST_LOADB;
          else                                           state_d = ST_LOADA;
        end
      end
      ST_LOADA: state_d = ST_LOADB;
      ST_LOADB: state_d = ST_EXEC;
      ST_EXEC: begin
        state_d     = ST_DISP;
        res_valid_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.CS = state_q;

  calc_ctrl_decode #(
    .AW     (AW),
    .OPW    (OPW),
    .A_ADDR (A_ADDR),
    .B_ADDR (B_ADDR),
    .R_ADDR (R_ADDR),
    .C_PASS (C_PASS)
  ) u_decode (
    .cs_i    (state_q),
    .op_i    (op_q),
    .chain_i (chain_q),
    .sel1_o  (bus.Sel1),
    .wa_o    (bus.WA),
    .we_o    (bus.WE),
    .raa_o   (bus.RAA),
    .rab_o   (bus.RAB),
    .rea_o   (bus.REA),
    .reb_o   (bus.REB),
    .c_o     (bus.C),
    .sel2_o  (bus.Sel2),
    .done_o  (bus.Done),
    .busy_o  (bus.Busy),
    .err_o   (bus.Err)
  );

endmodule

// File: tb/tb_calc_ctrl_unit.sv
// Directed, table-driven bench for calc_ctrl_unit with default parameters.
// Each table row holds the request applied before a rising edge and the full
// control word expected after that edge.
module tb_calc_ctrl_unit;

  logic CLK;
  logic RST;

  calc_ctrl_unit_if #(.AW(2), .OPW(3)) bus ();

  calc_ctrl_unit dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       go;
    logic       chain;
    logic [2:0] op;
    logic [2:0] cs;
    logic [1:0] sel1;
    logic [1:0] wa;
    logic       we;
    logic [1:0] raa;
    logic [1:0] rab;
    logic       rea;
    logic       reb;
    logic [2:0] c;
    logic       sel2;
    logic       done;
    logic       busy;
    logic       err;
  } vec_t;

  localparam int NV = 31;
  vec_t vecs [NV];
  vec_t e;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic chk_all(input int row, input vec_t x);
    chk("CS",   row, 32'(bus.CS),   32'(x.cs));
    chk("Sel1", row, 32'(bus.Sel1), 32'(x.sel1));
    chk("WA",   row, 32'(bus.WA),   32'(x.wa));
    chk("WE",   row, 32'(bus.WE),   32'(x.we));
    chk("RAA",  row, 32'(bus.RAA),  32'(x.raa));
    chk("RAB",  row, 32'(bus.RAB),  32'(x.rab));
    chk("REA",  row, 32'(bus.REA),  32'(x.rea));
    chk("REB",  row, 32'(bus.REB),  32'(x.reb));
    chk("C",    row, 32'(bus.C),    32'(x.c));
    chk("Sel2", row, 32'(bus.Sel2), 32'(x.sel2));
    chk("Done", row, 32'(bus.Done), 32'(x.done));
    chk("Busy", row, 32'(bus.Busy), 32'(x.busy));
    chk("Err",  row, 32'(bus.Err),  32'(x.err));
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    //           go ch op   cs  sel1 wa we raa rab rea reb c  s2 dn bz er
    // chain request before any result exists -> ERROR
    vecs[0]  = '{1, 1, 3,   5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    vecs[1]  = '{0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    // ADD, Op changed to 0 during LOADA
    vecs[2]  = '{1, 0, 3,   1, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    vecs[3]  = '{0, 0, 0,   2, 2, 2, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    vecs[4]  = '{0, 0, 0,   3, 0, 3, 1, 1, 2, 1, 1, 3, 0, 0, 1, 0};
    vecs[5]  = '{0, 0, 0,   4, 1, 0, 0, 3, 3, 1, 1, 1, 1, 1, 1, 0};
    vecs[6]  = '{0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    // chained SUB, Chain dropped mid-sequence
    vecs[7]  = '{1, 1, 2,   2, 2, 2, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    vecs[8]  = '{0, 0, 0,   3, 0, 3, 1, 3, 2, 1, 1, 2, 0, 0, 1, 0};
    // Go raised during EXEC and held: ignored until the IDLE sample
    vecs[9]  = '{1, 0, 4,   4, 1, 0, 0, 3, 3, 1, 1, 1, 1, 1, 1, 0};
    vecs[10] = '{1, 0, 4,   0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[11] = '{1, 0, 4,   1, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    vecs[12] = '{0, 0, 0,   2, 2, 2, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    vecs[13] = '{0, 0, 0,   3, 0, 3, 1, 1, 2, 1, 1, 4, 0, 0, 1, 0};
    // Go held through DISP with a chained AND queued behind it
    vecs[14] = '{1, 1, 1,   4, 1, 0, 0, 3, 3, 1, 1, 1, 1, 1, 1, 0};
    vecs[15] = '{1, 1, 1,   0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[16] = '{1, 1, 1,   2, 2, 2, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    vecs[17] = '{0, 0, 0,   3, 0, 3, 1, 3, 2, 1, 1, 1, 0, 0, 1, 0};
    vecs[18] = '{0, 0, 0,   4, 1, 0, 0, 3, 3, 1, 1, 1, 1, 1, 1, 0};
    vecs[19] = '{0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    // illegal ops 6, 5 (first illegal), 7 with chain
    vecs[20] = '{1, 0, 6,   5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    vecs[21] = '{0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[22] = '{1, 0, 5,   5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    vecs[23] = '{0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[24] = '{1, 1, 7,   5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    vecs[25] = '{0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    // op 0 (XOR) is legal
    vecs[26] = '{1, 0, 0,   1, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    vecs[27] = '{0, 0, 0,   2, 2, 2, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    vecs[28] = '{0, 0, 0,   3, 0, 3, 1, 1, 2, 1, 1, 0, 0, 0, 1, 0};
    vecs[29] = '{0, 0, 0,   4, 1, 0, 0, 3, 3, 1, 1, 1, 1, 1, 1, 0};
    vecs[30] = '{0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    bus.Go    = 1'b0;
    bus.Chain = 1'b0;
    bus.Op    = 3'd0;
    RST       = 1'b0;
    #1 RST    = 1'b1;
    #1;
    // reset state, observed while reset is held
    chk_all(-1, vecs[1]);
    #10 RST = 1'b0;

    for (int i = 0; i < NV; i++) begin
      bus.Go    = vecs[i].go;
      bus.Chain = vecs[i].chain;
      bus.Op    = vecs[i].op;
      tick();
      chk_all(i, vecs[i]);
    end

    // Reset in the middle of EXEC clears outputs before the next edge.
    bus.Go = 1'b1; bus.Chain = 1'b0; bus.Op = 3'd1;
    tick();
    bus.Go = 1'b0;
    tick();
    tick();
    chk("pre-reset CS", 100, 32'(bus.CS), 32'd3);
    chk("pre-reset WE", 100, 32'(bus.WE), 32'd1);
    #2 RST = 1'b1;
    #1;
    chk_all(101, vecs[1]);
    @(negedge CLK);
    RST = 1'b0;
    // res_valid was cleared, so a chain request now fails
    bus.Go = 1'b1; bus.Chain = 1'b1; bus.Op = 3'd3;
    tick();
    chk_all(102, vecs[0]);
    bus.Go = 1'b0; bus.Chain = 1'b0; bus.Op = 3'd0;
    tick();
    chk_all(103, vecs[1]);
    tick();
    chk_all(104, vecs[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
